cnt_seq_ctrl: RTL and testbench
===============================

// Module: cnt_seq_ctrl
// PURPOSE
//  Sequencer for the 4-bit count datapath: owns the count register and runs it
//  under start/stop/pause control with a programmable terminal value and clock
//  prescaler, in one-shot or auto-reload mode. Sits between the control/config
//  logic and the count consumer; reports busy and a one-cycle done pulse.
// PARAMETERS
//  CNT_W  4  width of count register and cfg_limit
//  PRE_W  8  width of prescaler and cfg_div
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rstn        in   1      asynchronous, active-low reset
//  start       in   1      start request, sampled in IDLE/DONE only
//  stop        in   1      abort request, highest priority
//  pause       in   1      level; freezes counting while high in RUN
//  cfg_limit   in   CNT_W  terminal count value
//  cfg_div     in   PRE_W  prescale: one count step per cfg_div+1 cycles
//  cfg_reload  in   1      1 = auto-reload to 0 after limit, 0 = one-shot
//  cnt         out  CNT_W  current count
//  busy        out  1      high while a count run is active
//  done        out  1      one-cycle pulse on the cycle cnt first equals limit
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rstn). Reset, incl.
//    mid-run: state=IDLE, cnt=0, prescaler=0, busy=0, done=0, shadows=0.
//  - States: IDLE, RUN, DONE. Pause is a qualifier inside RUN, not a state.
//  - IDLE/DONE + start (stop=0): latch cfg_limit/cfg_div/cfg_reload into shadow
//    regs, cnt<=0, pre<=0, ->RUN; busy=1 from next cycle. cfg changes during
//    a run are ignored.
//  - start with shadow limit==0: no RUN; done=1 next cycle, cnt=0, ->DONE,
//    busy stays 0 (reload ignored).
//  - RUN, pause=0: pre increments; when pre==div_s: pre<=0, step.
//    step: cnt<=cnt+1; if cnt+1==limit_s -> done=1 same cycle cnt shows limit.
//      one-shot: ->DONE, busy=0 in that same cycle, cnt holds limit.
//      reload : stay RUN, busy=1; next step cnt<=0 (sequence 0..limit,0..).
//  - Latency, div=0: start sampled at edge 0 -> cnt=0 @1, cnt=k @k+1,
//    done @limit+1. div=D: each value held D+1 cycles.
//  - RUN, pause=1: pre and cnt frozen, busy=1, no done.
//  - stop in RUN: ->IDLE next cycle, cnt=0, pre=0, busy=0, no done; beats
//    step, pause and a same-cycle done. stop in DONE: ->IDLE, cnt=0.
//    stop+start together: stop wins, start dropped.
//  - start while RUN: ignored (no restart, no error).
//  - cnt never exceeds limit_s; no wrap past 2^CNT_W-1. done never >1 cycle
//    wide except reload with div=0, limit=1 (pulses every other cycle).
//  - All outputs registered; no combinational input->output path.
// CONFIGURATION
//  CNT_SEQ_IRQ_EN defined: adds ports irq (out,1) and irq_clr (in,1). irq is
//    sticky: set on every done pulse, cleared by irq_clr; set wins if both in
//    same cycle; reset value 0.
//  Not defined: irq/irq_clr ports absent; done pulse is the only completion
//    indication; no other behaviour changes.
// TESTING
//  1 rstn=0 with start=1, cfg_limit=5 -> cnt=0, busy=0, done=0; irq=0 if EN.
//  2 limit=5,div=0,reload=0, start @0 -> cnt 0,1,..,5 @1..6; busy=1 @1..5;
//    done=1 only @6; cnt stays 5 afterwards.
//  3 limit=3,div=2,reload=1 -> each value held 3 cycles, sequence 0,1,2,3,0..;
//    done pulses once per cnt=3 entry, busy never drops.
//  4 limit=5,div=0; pause=1 for 4 cycles at cnt=2 -> cnt held at 2, done
//    moves from @6 to @10; busy stays 1.
//  5 stop at cnt=3 -> next cycle cnt=0, busy=0, done never asserts; a start
//    pulse at cnt=1 of a later run is ignored (sequence unchanged).
//  6 limit=0, start -> done=1 next cycle, busy=0 throughout; with
//    CNT_SEQ_IRQ_EN irq=1 until irq_clr, irq stays 1 if irq_clr meets done.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequencer that owns the count register.
// It runs the count under start/stop/pause control, with a programmable terminal
// value and a clock prescaler, in either one-shot or auto-reload mode.
// Optional feature macro: CNT_SEQ_IRQ_EN adds a sticky irq output with an irq_clr input.
// Without the macro the done pulse is the only completion indication.
module cnt_seq_ctrl #(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic [PRE_W-1:0] cfg_div,
  input  logic             cfg_reload,
`ifdef CNT_SEQ_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   limit_q, limit_d;   // shadow of cfg_limit for the current run
  logic [PRE_W-1:0]   div_q, div_d;       // shadow of cfg_div for the current run
  logic               reload_q, reload_d; // shadow of cfg_reload for the current run
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               pre_hit_s;

  assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign pre_hit_s = (pre_q == div_q);

  // Next-state logic for the sequencer: stop first, then start/pause/step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    limit_d  = limit_q;
    div_d    = div_q;
    reload_d = reload_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          // Stop also drops a same-cycle start.
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          pre_d   = {PRE_W{1'b0}};
          busy_d  = 1'b0;
        end else if (start) begin
          limit_d  = cfg_limit;
          div_d    = cfg_div;
          reload_d = cfg_reload;
          cnt_d    = {CNT_W{1'b0}};
          pre_d    = {PRE_W{1'b0}};
          if (cfg_limit == {CNT_W{1'b0}}) begin
            // A zero limit is reached immediately: no run, just the done pulse.
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Abort beats a pending step, pause and a same-cycle done.
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          pre_d   = {PRE_W{1'b0}};
          busy_d  = 1'b0;
        end else if (pause) begin
          pre_d = pre_q;
          cnt_d = cnt_q;
        end else if (pre_hit_s) begin
          pre_d = {PRE_W{1'b0}};
          if (cnt_q == limit_q) begin
            // Only reachable in reload mode: restart the sequence from 0.
            cnt_d = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == limit_q) begin
              done_d = 1'b1;
              if (!reload_q) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
              end else begin
                state_d = ST_RUN;
              end
            end else begin
              done_d = 1'b0;
            end
          end
        end else begin
          pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        pre_d   = {PRE_W{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state, count, prescaler, shadow config and registered flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      pre_q    <= {PRE_W{1'b0}};
      limit_q  <= {CNT_W{1'b0}};
      div_q    <= {PRE_W{1'b0}};
      reload_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      limit_q  <= limit_d;
      div_q    <= div_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef CNT_SEQ_IRQ_EN
  logic irq_q;

  // Sticky completion flag; set from the visible done pulse so that a clear
  // arriving in the same cycle as done loses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q <= 1'b0;
    end else if (done_q) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_q;
    end
  end

  assign irq = irq_q;
`endif

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl. Cycle c is the cycle after c edges have
// passed since start was sampled; outputs are read 1 time unit after each edge.
module tb_cnt_seq_ctrl;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] cfg_limit;
  logic [7:0] cfg_div;
  logic       cfg_reload;
  logic [3:0] cnt;
  logic       busy;
  logic       done;
`ifdef CNT_SEQ_IRQ_EN
  logic       irq_clr;
  logic       irq;
`endif

  int total;
  int bad;

  cnt_seq_ctrl #(.CNT_W(4), .PRE_W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .cfg_limit  (cfg_limit),
    .cfg_div    (cfg_div),
    .cfg_reload (cfg_reload),
`ifdef CNT_SEQ_IRQ_EN
    .irq_clr    (irq_clr),
    .irq        (irq),
`endif
    .cnt        (cnt),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    tick();
  endtask

  task automatic launch(input logic [3:0] lim, input logic [7:0] dv, input logic rl);
    cfg_limit  = lim;
    cfg_div    = dv;
    cfg_reload = rl;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rstn = 1'b0; start = 1'b1; cfg_limit = 4'd5;
    tick(); tick(); tick();
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_0) begin
      bad++;
      $display("FAIL reset_state: got cnt=%0d busy=%0b done=%0b want 0/0/0", cnt, busy, done);
    end
`ifdef CNT_SEQ_IRQ_EN
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got %0b want 0", irq);
    end
`endif
    start = 1'b0;
    rstn = 1'b1;
    tick();
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_0) begin
      bad++;
      $display("FAIL reset_release: got cnt=%0d busy=%0b done=%0b want 0/0/0", cnt, busy, done);
    end
  endtask

  task automatic test_oneshot();
    logic [5:0] obs, exp;
    int ec;
    launch(4'd5, 8'd0, 1'b0);
    cfg_limit = 4'd2;  // must be ignored during the run
    for (int c = 1; c <= 9; c++) begin
      ec  = (c - 1 > 5) ? 5 : c - 1;
      exp = {4'(ec), (c <= 5) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0};
      obs = {cnt, busy, done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL oneshot c=%0d: got cnt=%0d busy=%0b done=%0b want cnt=%0d busy=%0b done=%0b",
                 c, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
      end
      tick();
    end
  endtask

  task automatic test_reload_div();
    logic [5:0] obs, exp;
    int ec;
    go_idle();
    launch(4'd3, 8'd2, 1'b1);
    for (int c = 1; c <= 26; c++) begin
      ec  = ((c - 1) / 3) % 4;
      exp = {4'(ec), 1'b1, (((c - 1) % 3 == 0) && (ec == 3)) ? 1'b1 : 1'b0};
      obs = {cnt, busy, done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reload_div c=%0d: got cnt=%0d busy=%0b done=%0b want cnt=%0d busy=%0b done=%0b",
                 c, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_reload_fast();
    logic [5:0] obs, exp;
    launch(4'd1, 8'd0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      exp = {4'((c - 1) % 2), 1'b1, (c % 2 == 0) ? 1'b1 : 1'b0};
      obs = {cnt, busy, done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reload_fast c=%0d: got cnt=%0d busy=%0b done=%0b want cnt=%0d busy=%0b done=%0b",
                 c, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_pause();
    logic [5:0] obs, exp;
    int ec;
    launch(4'd5, 8'd0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 3)      ec = c - 1;
      else if (c <= 7) ec = 2;
      else             ec = (c - 5 > 5) ? 5 : c - 5;
      exp = {4'(ec), (c <= 9) ? 1'b1 : 1'b0, (c == 10) ? 1'b1 : 1'b0};
      obs = {cnt, busy, done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL pause c=%0d: got cnt=%0d busy=%0b done=%0b want cnt=%0d busy=%0b done=%0b",
                 c, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
      end
      pause = (c >= 3 && c <= 6) ? 1'b1 : 1'b0;
      tick();
    end
    pause = 1'b0;
    go_idle();
  endtask

  task automatic test_stop();
    logic [5:0] obs, exp;
    int ec;
    // stop at cnt=3
    launch(4'd5, 8'd0, 1'b0);
    tick(); tick(); tick();  // cycle 4, cnt=3
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      obs = {cnt, busy, done};
      total++;
      if (obs !== 6'b0000_0_0) begin
        bad++;
        $display("FAIL stop_run k=%0d: got cnt=%0d busy=%0b done=%0b want 0/0/0", k, cnt, busy, done);
      end
      tick();
    end
    // stop against the cycle that would produce done (cnt=4 -> 5)
    launch(4'd5, 8'd0, 1'b0);
    tick(); tick(); tick(); tick();  // cycle 5, cnt=4
    stop = 1'b1;
    tick();
    stop = 1'b0;
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_0) begin
      bad++;
      $display("FAIL stop_vs_done: got cnt=%0d busy=%0b done=%0b want 0/0/0", cnt, busy, done);
    end
    // stop and start together in IDLE: start dropped
    cfg_limit = 4'd5;
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    tick();
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_0) begin
      bad++;
      $display("FAIL stop_start: got cnt=%0d busy=%0b done=%0b want 0/0/0", cnt, busy, done);
    end
    // start while running is ignored
    launch(4'd5, 8'd0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      ec  = (c - 1 > 5) ? 5 : c - 1;
      exp = {4'(ec), (c <= 5) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0};
      obs = {cnt, busy, done};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL restart_ignored c=%0d: got cnt=%0d busy=%0b done=%0b want cnt=%0d busy=%0b done=%0b",
                 c, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
      end
      start = (c == 2) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    // stop in DONE returns to IDLE with cnt cleared
    stop = 1'b1;
    tick();
    stop = 1'b0;
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_0) begin
      bad++;
      $display("FAIL stop_in_done: got cnt=%0d busy=%0b done=%0b want 0/0/0", cnt, busy, done);
    end
  endtask

  task automatic test_zero_limit();
    logic [5:0] obs;
    launch(4'd0, 8'd0, 1'b1);
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_1) begin
      bad++;
      $display("FAIL zero_limit_done: got cnt=%0d busy=%0b done=%0b want 0/0/1", cnt, busy, done);
    end
    tick();
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_0) begin
      bad++;
      $display("FAIL zero_limit_after: got cnt=%0d busy=%0b done=%0b want 0/0/0", cnt, busy, done);
    end
`ifdef CNT_SEQ_IRQ_EN
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_set: got %0b want 1", irq);
    end
    tick();
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_sticky: got %0b want 1", irq);
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_clr: got %0b want 0", irq);
    end
    // clear held across the done cycle: set wins
    irq_clr = 1'b1;
    launch(4'd0, 8'd0, 1'b0);
    tick();
    irq_clr = 1'b0;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_set_wins: got %0b want 1", irq);
    end
`endif
    go_idle();
  endtask

  task automatic test_reset_midrun();
    logic [5:0] obs;
    launch(4'd5, 8'd0, 1'b0);
    tick(); tick(); tick();  // cnt=3
    #2;
    rstn = 1'b0;
    #1;
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_0) begin
      bad++;
      $display("FAIL reset_midrun: got cnt=%0d busy=%0b done=%0b want 0/0/0", cnt, busy, done);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick(); tick();
    obs = {cnt, busy, done};
    total++;
    if (obs !== 6'b0000_0_0) begin
      bad++;
      $display("FAIL reset_midrun_idle: got cnt=%0d busy=%0b done=%0b want 0/0/0", cnt, busy, done);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    cfg_limit = 4'd0;
    cfg_div = 8'd0;
    cfg_reload = 1'b0;
`ifdef CNT_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    test_reset();
    test_oneshot();
    test_reload_div();
    test_reload_fast();
    test_pause();
    test_stop();
    test_zero_limit();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
